hub75_rx: RTL and testbench

- Receive-side counterpart of the HUB75 panel driver.
- Oversamples the HUB75 pins (clk, lat, oe_, row, r0/g0/b0/r1/g1/b1) on the local clock and decodes shifted pixels into a pixel stream.
- Reports one record per latched line and one record per OE-on pulse.
- Sits in the simulation bench and, optionally, in a loopback FPGA build to check the driver's output against expected frame content.

---
 rtl/hub75_pkg.sv | 27 ++
 rtl/hub75_rx_if.sv | 27 ++
 rtl/hub75_sync_edge.sv | 39 +++
 rtl/hub75.sv | 146 ++++++++++++++
 tb/tb_hub75_rx.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hub75_pkg.sv
// Shared constants and record types for the HUB75 receive-side monitor.
package hub75_pkg;

    localparam int HUB75_ROW_BITS    = 3;
    localparam int HUB75_NR_COLS     = 32;
    localparam int HUB75_OE_CNT_BITS = 16;
    localparam int HUB75_COL_BITS    = $clog2(HUB75_NR_COLS);

    typedef logic [2:0] rgb_t;

    typedef struct packed {
        logic [HUB75_ROW_BITS-1:0] row;
        logic [HUB75_COL_BITS:0]   nr_cols;
        logic                      overflow;
    } line_rec_t;

    typedef struct packed {
        logic [HUB75_ROW_BITS-1:0]    row;
        logic [HUB75_OE_CNT_BITS-1:0] cycles;
    } oe_rec_t;

    typedef enum logic {
        OE_OFF,
        OE_ON
    } oe_state_t;

endpackage

// File: rtl/hub75_rx_if.sv
// HUB75 panel pin bundle: the driver side is the master, the receiver/monitor the slave.
import hub75_pkg::*;

interface hub75_rx_if #(
    parameter int ROW_BITS = HUB75_ROW_BITS
);
    logic                hub75_clk;
    logic                hub75_lat;
    logic                hub75_oe_;
    logic [ROW_BITS-1:0] hub75_row;
    logic                hub75_r0;
    logic                hub75_g0;
    logic                hub75_b0;
    logic                hub75_r1;
    logic                hub75_g1;
    logic                hub75_b1;

    modport master (
        output hub75_clk, hub75_lat, hub75_oe_, hub75_row,
        output hub75_r0, hub75_g0, hub75_b0, hub75_r1, hub75_g1, hub75_b1
    );

    modport slave (
        input hub75_clk, hub75_lat, hub75_oe_, hub75_row,
        input hub75_r0, hub75_g0, hub75_b0, hub75_r1, hub75_g1, hub75_b1
    );
endinterface

// File: rtl/hub75_sync_edge.sv
// Two-flop synchroniser plus history register over a bus, with per-bit rise/fall strobes.
import hub75_pkg::*;

module hub75_sync_edge #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] hist;
    logic [2:0]       primed;

    // primed marks when sync and hist both hold real pin samples, so a pin
    // sitting at a non-idle level across reset release never looks like an edge.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            meta   <= RESET_VAL;
            sync   <= RESET_VAL;
            hist   <= RESET_VAL;
            primed <= '0;
        end else begin
            meta   <= din;
            sync   <= meta;
            hist   <= sync;
            primed <= {primed[1:0], 1'b1};
        end
    end

    assign rise = primed[2] ? (sync & ~hist) : '0;
    assign fall = primed[2] ? (~sync & hist) : '0;

endmodule

// File: rtl/hub75.sv
// HUB75 receiver: decodes oversampled panel pins into pixel, line-latch and OE-pulse records.
import hub75_pkg::*;

module hub75_rx #(
    parameter int NR_COLS     = HUB75_NR_COLS,
    parameter int ROW_BITS    = HUB75_ROW_BITS,
    parameter int OE_CNT_BITS = HUB75_OE_CNT_BITS
) (
    input  logic                         clk,
    input  logic                         reset_,
    hub75_rx_if.slave                    hub,
    output logic                         pix_valid,
    output logic [$clog2(NR_COLS)-1:0]   pix_col,
    output rgb_t                         pix_rgb0,
    output rgb_t                         pix_rgb1,
    output logic                         line_valid,
    output logic [ROW_BITS-1:0]          line_row,
    output logic [$clog2(NR_COLS):0]     line_nr_cols,
    output logic                         line_overflow,
    output logic                         oe_valid,
    output logic [ROW_BITS-1:0]          oe_row,
    output logic [OE_CNT_BITS-1:0]       oe_cycles
);

    localparam int COL_BITS = $clog2(NR_COLS);
    localparam int W        = ROW_BITS + 9;
    localparam int CLK_BIT  = W - 1;
    localparam int LAT_BIT  = W - 2;
    localparam int OE_BIT   = W - 3;
    localparam logic [W-1:0]        IDLE_PINS = W'(1) << OE_BIT;
    localparam logic [COL_BITS:0]   COL_LIMIT = (COL_BITS + 1)'(NR_COLS);

    logic [W-1:0] raw_pins;
    logic [W-1:0] sync_pins;
    logic [W-1:0] rise;
    logic [W-1:0] fall;

    assign raw_pins = {hub.hub75_clk, hub.hub75_lat, hub.hub75_oe_, hub.hub75_row,
                       hub.hub75_r0, hub.hub75_g0, hub.hub75_b0,
                       hub.hub75_r1, hub.hub75_g1, hub.hub75_b1};

    // One synchroniser over the whole bus keeps data, row, lat and oe_ aligned with clk.
    hub75_sync_edge #(
        .WIDTH     (W),
        .RESET_VAL (IDLE_PINS)
    ) u_sync (
        .clk    (clk),
        .reset_ (reset_),
        .din    (raw_pins),
        .sync   (sync_pins),
        .rise   (rise),
        .fall   (fall)
    );

    logic                clk_rise;
    logic                lat_rise;
    logic [ROW_BITS-1:0] row_s;
    logic                unused_edges;

    assign clk_rise     = rise[CLK_BIT];
    assign lat_rise     = rise[LAT_BIT];
    assign row_s        = sync_pins[W-4 -: ROW_BITS];
    assign unused_edges = ^{rise[W-4:0], fall[W-1:W-2], fall[W-4:0], sync_pins[W-1:W-3]};

    logic [COL_BITS:0] col_cnt;
    logic [COL_BITS:0] col_next;
    logic              ovf;
    logic              ovf_next;
    logic              pix_take;

    // A pixel arriving together with the latch is counted into the line being closed.
    always_comb begin
        pix_take = clk_rise && (col_cnt < COL_LIMIT);
        col_next = pix_take ? col_cnt + 1'b1 : col_cnt;
        ovf_next = ovf | (clk_rise & ~pix_take);
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            pix_valid     <= 1'b0;
            pix_col       <= '0;
            pix_rgb0      <= '0;
            pix_rgb1      <= '0;
            line_valid    <= 1'b0;
            line_row      <= '0;
            line_nr_cols  <= '0;
            line_overflow <= 1'b0;
            col_cnt       <= '0;
            ovf           <= 1'b0;
        end else begin
            pix_valid  <= pix_take;
            line_valid <= lat_rise;
            if (pix_take) begin
                pix_col  <= col_cnt[COL_BITS-1:0];
                pix_rgb0 <= sync_pins[5:3];
                pix_rgb1 <= sync_pins[2:0];
            end
            if (lat_rise) begin
                line_row      <= row_s;
                line_nr_cols  <= col_next;
                line_overflow <= ovf_next;
                col_cnt       <= '0;
                ovf           <= 1'b0;
            end else begin
                col_cnt <= col_next;
                ovf     <= ovf_next;
            end
        end
    end

    oe_state_t              oe_state;
    logic [OE_CNT_BITS-1:0] oe_cnt;

    // The row is captured once at OE entry; later row changes inside the pulse are ignored.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            oe_state  <= OE_OFF;
            oe_cnt    <= '0;
            oe_valid  <= 1'b0;
            oe_row    <= '0;
            oe_cycles <= '0;
        end else begin
            oe_valid <= 1'b0;
            case (oe_state)
                OE_OFF: begin
                    if (fall[OE_BIT]) begin
                        oe_state <= OE_ON;
                        oe_row   <= row_s;
                        oe_cnt   <= OE_CNT_BITS'(1);
                    end
                end
                OE_ON: begin
                    if (rise[OE_BIT]) begin
                        oe_state  <= OE_OFF;
                        oe_valid  <= 1'b1;
                        oe_cycles <= oe_cnt;
                    end else if (oe_cnt != '1) begin
                        oe_cnt <= oe_cnt + 1'b1;
                    end
                end
                default: oe_state <= OE_OFF;
            endcase
        end
    end

endmodule

// File: tb/tb_hub75_rx.sv
// Directed bench for hub75_rx: shifts lines, latches and OE pulses and checks the decoded records.
import hub75_pkg::*;

module tb_hub75_rx;

    logic clk = 1'b0;
    logic reset_ = 1'b0;

    always #5 clk = ~clk;

    hub75_rx_if bus ();

    logic                        pix_valid;
    logic [HUB75_COL_BITS-1:0]   pix_col;
    rgb_t                        pix_rgb0;
    rgb_t                        pix_rgb1;
    logic                        line_valid;
    logic [HUB75_ROW_BITS-1:0]   line_row;
    logic [HUB75_COL_BITS:0]     line_nr_cols;
    logic                        line_overflow;
    logic                        oe_valid;
    logic [HUB75_ROW_BITS-1:0]   oe_row;
    logic [15:0]                 oe_cycles;

    logic                        d4_pix_valid;
    logic [HUB75_COL_BITS-1:0]   d4_pix_col;
    rgb_t                        d4_pix_rgb0;
    rgb_t                        d4_pix_rgb1;
    logic                        d4_line_valid;
    logic [HUB75_ROW_BITS-1:0]   d4_line_row;
    logic [HUB75_COL_BITS:0]     d4_line_nr_cols;
    logic                        d4_line_overflow;
    logic                        d4_oe_valid;
    logic [HUB75_ROW_BITS-1:0]   d4_oe_row;
    logic [3:0]                  d4_oe_cycles;

    hub75_rx dut (
        .clk           (clk),
        .reset_        (reset_),
        .hub           (bus),
        .pix_valid     (pix_valid),
        .pix_col       (pix_col),
        .pix_rgb0      (pix_rgb0),
        .pix_rgb1      (pix_rgb1),
        .line_valid    (line_valid),
        .line_row      (line_row),
        .line_nr_cols  (line_nr_cols),
        .line_overflow (line_overflow),
        .oe_valid      (oe_valid),
        .oe_row        (oe_row),
        .oe_cycles     (oe_cycles)
    );

    hub75_rx #(.OE_CNT_BITS(4)) dut4 (
        .clk           (clk),
        .reset_        (reset_),
        .hub           (bus),
        .pix_valid     (d4_pix_valid),
        .pix_col       (d4_pix_col),
        .pix_rgb0      (d4_pix_rgb0),
        .pix_rgb1      (d4_pix_rgb1),
        .line_valid    (d4_line_valid),
        .line_row      (d4_line_row),
        .line_nr_cols  (d4_line_nr_cols),
        .line_overflow (d4_line_overflow),
        .oe_valid      (d4_oe_valid),
        .oe_row        (d4_oe_row),
        .oe_cycles     (d4_oe_cycles)
    );

    typedef struct packed {
        logic [HUB75_COL_BITS-1:0] col;
        rgb_t                      rgb0;
        rgb_t                      rgb1;
    } pix_rec_t;

    pix_rec_t   pix_q[$];
    line_rec_t  line_q[$];
    oe_rec_t    oe_q[$];
    logic [3:0] oe4_q[$];

    int compared   = 0;
    int mismatched = 0;
    int last_lat   = 0;

    // Every output pulse is logged on the falling edge and checked after the stimulus settles.
    always @(negedge clk) begin
        if (pix_valid)   pix_q.push_back({pix_col, pix_rgb0, pix_rgb1});
        if (line_valid)  line_q.push_back({line_row, line_nr_cols, line_overflow});
        if (oe_valid)    oe_q.push_back({oe_row, oe_cycles});
        if (d4_oe_valid) oe4_q.push_back(d4_oe_cycles);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic flushQueues();
        pix_q.delete();
        line_q.delete();
        oe_q.delete();
        oe4_q.delete();
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One shift-clock pulse with data held two cycles either side; optionally latches on the same edge.
    task automatic applyStimulus(input rgb_t c0, input rgb_t c1, input logic with_lat,
                                 input logic [HUB75_ROW_BITS-1:0] row);
        int lat;
        @(negedge clk);
        {bus.hub75_r0, bus.hub75_g0, bus.hub75_b0} = c0;
        {bus.hub75_r1, bus.hub75_g1, bus.hub75_b1} = c1;
        bus.hub75_row = row;
        waitCycles(2);
        bus.hub75_clk = 1'b1;
        if (with_lat) bus.hub75_lat = 1'b1;
        lat = 0;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            if (pix_valid && lat == 0) lat = i;
        end
        last_lat = lat;
        @(negedge clk);
        bus.hub75_clk = 1'b0;
        bus.hub75_lat = 1'b0;
        waitCycles(2);
    endtask

    task automatic applyLatch(input logic [HUB75_ROW_BITS-1:0] row);
        @(negedge clk);
        bus.hub75_row = row;
        waitCycles(2);
        bus.hub75_lat = 1'b1;
        waitCycles(3);
        bus.hub75_lat = 1'b0;
        waitCycles(3);
    endtask

    task automatic applyOe(input logic [HUB75_ROW_BITS-1:0] row, input int cycles,
                           input logic [HUB75_ROW_BITS-1:0] row_mid);
        @(negedge clk);
        bus.hub75_row = row;
        waitCycles(2);
        bus.hub75_oe_ = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            if (i == cycles / 2) bus.hub75_row = row_mid;
            @(negedge clk);
        end
        bus.hub75_oe_ = 1'b1;
        waitCycles(6);
    endtask

    task automatic getPix(output pix_rec_t r);
        r = (pix_q.size() > 0) ? pix_q.pop_front() : '1;
    endtask

    task automatic getLine(output line_rec_t r);
        r = (line_q.size() > 0) ? line_q.pop_front() : '1;
    endtask

    task automatic getOe(output oe_rec_t r);
        r = (oe_q.size() > 0) ? oe_q.pop_front() : '1;
    endtask

    task automatic getOe4(output logic [3:0] r);
        r = (oe4_q.size() > 0) ? oe4_q.pop_front() : 4'hx;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        pix_rec_t   p;
        line_rec_t  l;
        oe_rec_t    o;
        logic [3:0] o4;

        bus.hub75_clk = 1'b0;
        bus.hub75_lat = 1'b0;
        bus.hub75_oe_ = 1'b1;
        bus.hub75_row = '0;
        {bus.hub75_r0, bus.hub75_g0, bus.hub75_b0} = 3'b000;
        {bus.hub75_r1, bus.hub75_g1, bus.hub75_b1} = 3'b000;
        waitCycles(3);
        checkOutput("init_pix_valid", {31'd0, pix_valid}, 0);
        checkOutput("init_line_valid", {31'd0, line_valid}, 0);
        checkOutput("init_oe_valid", {31'd0, oe_valid}, 0);
        reset_ = 1'b1;
        waitCycles(5);

        // Full line with column-derived data, latched on row 5.
        flushQueues();
        for (int c = 0; c < 32; c++) begin
            applyStimulus(3'(c), ~3'(c), 1'b0, '0);
            if (c == 0) checkOutput("pix_latency", last_lat, 3);
        end
        applyLatch(3'd5);
        waitCycles(4);
        checkOutput("full_pix_count", pix_q.size(), 32);
        for (int c = 0; c < 32; c++) begin
            getPix(p);
            checkOutput("full_pix_col", {27'd0, p.col}, c);
            checkOutput("full_pix_rgb0", {29'd0, p.rgb0}, c % 8);
            checkOutput("full_pix_rgb1", {29'd0, p.rgb1}, 7 - (c % 8));
        end
        checkOutput("full_line_count", line_q.size(), 1);
        getLine(l);
        checkOutput("full_line_row", {29'd0, l.row}, 5);
        checkOutput("full_line_nr", {26'd0, l.nr_cols}, 32);
        checkOutput("full_line_ovf", {31'd0, l.overflow}, 0);

        // Two surplus shift pulses overflow the line; the following short line is clean.
        flushQueues();
        for (int c = 0; c < 34; c++) applyStimulus(3'b101, 3'b010, 1'b0, '0);
        applyLatch(3'd2);
        waitCycles(4);
        checkOutput("ovf_pix_count", pix_q.size(), 32);
        getLine(l);
        checkOutput("ovf_line_row", {29'd0, l.row}, 2);
        checkOutput("ovf_line_nr", {26'd0, l.nr_cols}, 32);
        checkOutput("ovf_line_ovf", {31'd0, l.overflow}, 1);
        flushQueues();
        for (int c = 0; c < 4; c++) applyStimulus(3'b001, 3'b110, 1'b0, '0);
        applyLatch(3'd6);
        waitCycles(4);
        checkOutput("short_pix_count", pix_q.size(), 4);
        getLine(l);
        checkOutput("short_line_nr", {26'd0, l.nr_cols}, 4);
        checkOutput("short_line_ovf", {31'd0, l.overflow}, 0);

        // Shift clock and latch rising together after ten pixels.
        flushQueues();
        for (int c = 0; c < 10; c++) applyStimulus(3'b010, 3'b100, 1'b0, '0);
        applyStimulus(3'b111, 3'b000, 1'b1, 3'd7);
        waitCycles(4);
        checkOutput("same_pix_count", pix_q.size(), 11);
        while (pix_q.size() > 1) void'(pix_q.pop_front());
        getPix(p);
        checkOutput("same_pix_col", {27'd0, p.col}, 10);
        checkOutput("same_pix_rgb0", {29'd0, p.rgb0}, 7);
        getLine(l);
        checkOutput("same_line_row", {29'd0, l.row}, 7);
        checkOutput("same_line_nr", {26'd0, l.nr_cols}, 11);
        flushQueues();
        applyStimulus(3'b011, 3'b001, 1'b0, '0);
        applyLatch(3'd0);
        waitCycles(4);
        getPix(p);
        checkOutput("next_pix_col", {27'd0, p.col}, 0);
        getLine(l);
        checkOutput("next_line_nr", {26'd0, l.nr_cols}, 1);

        // OE pulses: row held from entry, saturation on the 4-bit counter instance.
        flushQueues();
        applyOe(3'd3, 100, 3'd4);
        checkOutput("oe100_count", oe_q.size(), 1);
        getOe(o);
        checkOutput("oe100_row", {29'd0, o.row}, 3);
        checkOutput("oe100_cycles", {16'd0, o.cycles}, 100);
        getOe4(o4);
        checkOutput("oe100_sat4", {28'd0, o4}, 15);
        flushQueues();
        applyOe(3'd1, 40, 3'd1);
        getOe(o);
        checkOutput("oe40_cycles", {16'd0, o.cycles}, 40);
        getOe4(o4);
        checkOutput("oe40_sat4", {28'd0, o4}, 15);
        flushQueues();
        applyOe(3'd2, 9, 3'd2);
        getOe(o);
        checkOutput("oe9_cycles", {16'd0, o.cycles}, 9);
        getOe4(o4);
        checkOutput("oe9_nosat4", {28'd0, o4}, 9);

        // Reset mid-line with OE low: partial line and open OE pulse are both dropped.
        flushQueues();
        @(negedge clk);
        bus.hub75_oe_ = 1'b0;
        waitCycles(3);
        for (int c = 0; c < 7; c++) applyStimulus(3'b110, 3'b011, 1'b0, '0);
        waitCycles(2);
        flushQueues();
        @(negedge clk);
        reset_ = 1'b0;
        waitCycles(2);
        checkOutput("rst_pix_col", {27'd0, pix_col}, 0);
        checkOutput("rst_pix_rgb0", {29'd0, pix_rgb0}, 0);
        checkOutput("rst_pix_rgb1", {29'd0, pix_rgb1}, 0);
        checkOutput("rst_line_nr", {26'd0, line_nr_cols}, 0);
        checkOutput("rst_oe_row", {29'd0, oe_row}, 0);
        checkOutput("rst_oe_cycles", {16'd0, oe_cycles}, 0);
        checkOutput("rst_valids", {29'd0, pix_valid, line_valid, oe_valid}, 0);
        reset_ = 1'b1;
        waitCycles(5);
        applyLatch(3'd1);
        waitCycles(4);
        checkOutput("rst_line_count", line_q.size(), 1);
        getLine(l);
        checkOutput("rst_line_row", {29'd0, l.row}, 1);
        checkOutput("rst_line_nr0", {26'd0, l.nr_cols}, 0);
        checkOutput("rst_line_ovf", {31'd0, l.overflow}, 0);
        checkOutput("rst_pix_none", pix_q.size(), 0);
        @(negedge clk);
        bus.hub75_oe_ = 1'b1;
        waitCycles(10);
        checkOutput("rst_oe_none", oe_q.size(), 0);
        checkOutput("rst_oe4_none", oe4_q.size(), 0);
        flushQueues();
        applyOe(3'd6, 20, 3'd6);
        checkOutput("post_rst_oe_count", oe_q.size(), 1);
        getOe(o);
        checkOutput("post_rst_oe_row", {29'd0, o.row}, 6);
        checkOutput("post_rst_oe_cycles", {16'd0, o.cycles}, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
